// File: rtl/odev1_test_sequencer.sv
// Self-check sequencer for the 3-in/2-out homework circuit: sweeps ABC = 0..7,
// waits SETTLE_CYCLES per vector, and scores F/Q against expected truth tables.
module odev1_test_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [7:0]  EXP_F         = 8'hFE,
   parameter logic [7:0]  EXP_Q         = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [2:0] abc_out,
   input  logic       f_in,
   input  logic       q_in,
   output logic       busy,
   output logic       done,
   output logic [4:0] pass_count,
   output logic [4:0] fail_count,
   output logic [7:0] fail_vec,
   output logic       all_pass
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0] state;
   logic [2:0] idx;
   logic [3:0] cnt;
   logic       f_ok;
   logic       q_ok;
   logic [4:0] pass_inc;
   logic [4:0] fail_inc;

   // F and Q are scored independently, so one vector contributes 0, 1 or 2 to each count
   always_comb begin
      f_ok     = (f_in == EXP_F[idx]);
      q_ok     = (q_in == EXP_Q[idx]);
      pass_inc = {4'b0000, f_ok} + {4'b0000, q_ok};
      fail_inc = {4'b0000, ~f_ok} + {4'b0000, ~q_ok};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         cnt        <= '0;
         abc_out    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass_count <= '0;
         fail_count <= '0;
         fail_vec   <= '0;
         all_pass   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_SETTLE;
                  busy       <= 1'b1;
                  idx        <= '0;
                  cnt        <= '0;
                  abc_out    <= '0;
                  pass_count <= '0;
                  fail_count <= '0;
                  fail_vec   <= '0;
                  all_pass   <= 1'b0;
               end
            end
            S_SETTLE: begin
               cnt <= cnt + 4'd1;
               if (cnt == SETTLE_LAST) begin
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               pass_count <= pass_count + pass_inc;
               fail_count <= fail_count + fail_inc;
               if (!(f_ok && q_ok)) begin
                  fail_vec[idx] <= 1'b1;
               end
               if (idx == 3'd7) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
               end else begin
                  idx     <= idx + 3'd1;
                  abc_out <= idx + 3'd1;
                  cnt     <= '0;
                  state   <= S_SETTLE;
               end
            end
            S_DONE: begin
               done     <= 1'b1;
               all_pass <= (pass_count == 5'd16);
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_odev1_test_sequencer.sv
// Scoreboard bench for odev1_test_sequencer: two instances (SETTLE_CYCLES 1 and 3)
// driving a behavioural model of the homework circuit with selectable faults.
module tb_odev1_test_sequencer;

   typedef struct {
      logic [4:0] pc;
      logic [4:0] fc;
      logic [7:0] fv;
      logic       ap;
      int         at_edge;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // ---- instance with SETTLE_CYCLES = 1 ----
   logic       rst1, start1, f1, q1_in, busy1, done1, ap1;
   logic [2:0] abc1;
   logic [4:0] pass1, fail1;
   logic [7:0] fv1;
   logic [1:0] mode1;

   // mode 0: F=A|B|C, Q=1; mode 1: F stuck-at-0; mode 2: F inverted, Q stuck-at-0
   assign f1    = (mode1 == 2'd0) ? (|abc1) : (mode1 == 2'd1) ? 1'b0 : ~(|abc1);
   assign q1_in = (mode1 == 2'd2) ? 1'b0 : 1'b1;

   odev1_test_sequencer #(.SETTLE_CYCLES(1), .EXP_F(8'hFE), .EXP_Q(8'hFF)) u_dut1 (
      .clk(clk), .rst(rst1), .start(start1), .abc_out(abc1), .f_in(f1), .q_in(q1_in),
      .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
      .fail_vec(fv1), .all_pass(ap1)
   );

   // ---- instance with SETTLE_CYCLES = 3, correct circuit ----
   logic       rst3, start3, busy3, done3, ap3;
   logic [2:0] abc3;
   logic [4:0] pass3, fail3;
   logic [7:0] fv3;

   odev1_test_sequencer #(.SETTLE_CYCLES(3), .EXP_F(8'hFE), .EXP_Q(8'hFF)) u_dut3 (
      .clk(clk), .rst(rst3), .start(start3), .abc_out(abc3), .f_in(|abc3), .q_in(1'b1),
      .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3),
      .fail_vec(fv3), .all_pass(ap3)
   );

   exp_t q1[$];
   exp_t q3[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // ---- monitors: pop an expectation whenever a done pulse is presented ----
   logic prev_done1 = 1'b0;
   logic prev_done3 = 1'b0;
   exp_t m1, m3;

   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         check("done1_single_cycle", {31'd0, prev_done1}, 32'd0);
         if (q1.size() == 0) begin
            check("done1_unexpected", {31'd0, done1}, 32'd0);
         end else begin
            m1 = q1.pop_front();
            check("done1_cycle", cyc - 1, m1.at_edge);
            check("pass_count1", {27'd0, pass1}, {27'd0, m1.pc});
            check("fail_count1", {27'd0, fail1}, {27'd0, m1.fc});
            check("fail_vec1",   {24'd0, fv1},   {24'd0, m1.fv});
            check("all_pass1",   {31'd0, ap1},   {31'd0, m1.ap});
         end
      end
      prev_done1 <= done1;
   end

   always @(negedge clk) begin
      if (done3 === 1'b1) begin
         check("done3_single_cycle", {31'd0, prev_done3}, 32'd0);
         if (q3.size() == 0) begin
            check("done3_unexpected", {31'd0, done3}, 32'd0);
         end else begin
            m3 = q3.pop_front();
            check("done3_cycle", cyc - 1, m3.at_edge);
            check("pass_count3", {27'd0, pass3}, {27'd0, m3.pc});
            check("fail_count3", {27'd0, fail3}, {27'd0, m3.fc});
            check("fail_vec3",   {24'd0, fv3},   {24'd0, m3.fv});
            check("all_pass3",   {31'd0, ap3},   {31'd0, m3.ap});
         end
      end
      prev_done3 <= done3;
   end

   task automatic wait_drain(input int sel);
      int n = 0;
      while (((sel == 1) ? q1.size() : q3.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sel == 1 && q1.size() != 0) begin
         check("drain1_timeout", q1.size(), 0);
         q1.delete();
      end
      if (sel == 3 && q3.size() != 0) begin
         check("drain3_timeout", q3.size(), 0);
         q3.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_zero1(input string tag);
      check({tag, "_abc"},  {29'd0, abc1},  32'd0);
      check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
      check({tag, "_done"}, {31'd0, done1}, 32'd0);
      check({tag, "_pass"}, {27'd0, pass1}, 32'd0);
      check({tag, "_fail"}, {27'd0, fail1}, 32'd0);
      check({tag, "_fvec"}, {24'd0, fv1},   32'd0);
      check({tag, "_allp"}, {31'd0, ap1},   32'd0);
   endtask

   // run one pulsed sweep on instance 1 and check abc_out/busy stepping
   task automatic run1(input logic [1:0] mode, input exp_t e);
      int e0;
      mode1  = mode;
      e0     = cyc;
      e.at_edge = e0 + 17;
      q1.push_back(e);
      start1 = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         check("abc1_step", {29'd0, abc1}, k / 2);
         check("busy1_run", {31'd0, busy1}, 32'd1);
      end
      wait_drain(1);
   endtask

   initial begin
      int e0;
      exp_t e;
      rst1 = 1'b1; start1 = 1'b0; mode1 = 2'd0;
      rst3 = 1'b1; start3 = 1'b0;
      repeat (3) @(negedge clk);
      check_zero1("reset1");
      check("reset3_pass", {27'd0, pass3}, 32'd0);
      check("reset3_busy", {31'd0, busy3}, 32'd0);
      rst1 = 1'b0; rst3 = 1'b0;
      @(negedge clk);

      // correct circuit
      e = '{pc: 5'd16, fc: 5'd0, fv: 8'h00, ap: 1'b1, at_edge: 0};
      run1(2'd0, e);
      // F stuck-at-0, Q correct
      e = '{pc: 5'd9, fc: 5'd7, fv: 8'hFE, ap: 1'b0, at_edge: 0};
      run1(2'd1, e);
      // F inverted, Q stuck-at-0
      e = '{pc: 5'd0, fc: 5'd16, fv: 8'hFF, ap: 1'b0, at_edge: 0};
      run1(2'd2, e);
      repeat (4) @(negedge clk);
      check("hold1_fail", {27'd0, fail1}, 32'd16);
      check("hold1_fvec", {24'd0, fv1},   32'h0FF);

      // reset during SETTLE of vector 3
      mode1 = 2'd0;
      start1 = 1'b1;
      repeat (7) @(negedge clk) start1 = 1'b0;
      check("abc1_before_rst", {29'd0, abc1}, 32'd3);
      check("busy1_before_rst", {31'd0, busy1}, 32'd1);
      check("pass1_before_rst", {27'd0, pass1}, 32'd6);
      rst1 = 1'b1;
      @(negedge clk);
      check_zero1("midrun_rst");
      rst1 = 1'b0;
      repeat (20) @(negedge clk);
      check("idle1_busy", {31'd0, busy1}, 32'd0);
      e = '{pc: 5'd16, fc: 5'd0, fv: 8'h00, ap: 1'b1, at_edge: 0};
      run1(2'd0, e);

      // start held high: back-to-back runs 18 cycles apart
      e0 = cyc;
      e = '{pc: 5'd16, fc: 5'd0, fv: 8'h00, ap: 1'b1, at_edge: e0 + 17};
      q1.push_back(e);
      e.at_edge = e0 + 35;
      q1.push_back(e);
      start1 = 1'b1;
      repeat (19) @(negedge clk);
      check("b2b_cleared_pass", {27'd0, pass1}, 32'd0);
      check("b2b_cleared_allp", {31'd0, ap1},   32'd0);
      check("b2b_busy",         {31'd0, busy1}, 32'd1);
      start1 = 1'b0;
      wait_drain(1);
      repeat (20) @(negedge clk);

      // SETTLE_CYCLES = 3 with stray starts mid-run
      e0 = cyc;
      e = '{pc: 5'd16, fc: 5'd0, fv: 8'h00, ap: 1'b1, at_edge: e0 + 33};
      q3.push_back(e);
      start3 = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         start3 = (k + 1 == 5 || k + 1 == 20) ? 1'b1 : 1'b0;
         check("abc3_step", {29'd0, abc3}, k / 4);
         check("busy3_run", {31'd0, busy3}, 32'd1);
      end
      start3 = 1'b0;
      wait_drain(3);
      repeat (40) @(negedge clk);
      check("q1_empty", q1.size(), 0);
      check("q3_empty", q3.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100us;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
